module_arbitro_de_bus: RTL and testbench
========================================

Name: module_arbitro_de_bus

Overview:
Two-master arbiter and sequencer for the single memory-mapped data bus that feeds the bus conductor (RAM, switches, LEDs, 7-seg, UART A/B/C). Master 0 is the CPU data port and master 1 is the UART-to-RAM loader (DMA). The block grants the bus round-robin and supports bounded bus locking. It drives one registered request (we/addr/wdata) to the conductor and returns read data with a one-cycle ack.

Parameters:
DATA_W, 32, data width of bus and masters
ADDR_W, 32, address width
RD_LAT, 1, cycles from address drive to valid bus_rdata_i (0..7)
MAX_LOCK, 4, max consecutive locked transactions per owner (1..15)

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous reset, active-high
m0_req_i  in  1  master 0 request, held until m0_ack_o
m0_we_i  in  1  master 0 write enable (1 = write)
m0_addr_i  in  ADDR_W  master 0 address
m0_wdata_i  in  DATA_W  master 0 write data
m0_lock_i  in  1  master 0 requests to keep the bus after the current transfer
m0_ack_o  out  1  one-cycle completion pulse
m0_rdata_o  out  DATA_W  master 0 read data, valid with ack
m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_lock_i, m1_ack_o, m1_rdata_o  same as m0_* for master 1
bus_we_o  out  1  write enable to conductor (we_i)
bus_addr_o  out  ADDR_W  address to conductor (addr_i)
bus_wdata_o  out  DATA_W  write data to peripherals
bus_rdata_i  in  DATA_W  read data from conductor (d_out_o)
grant_o  out  2  one-hot current owner; 00 when idle
busy_o  out  1  high whenever state is not IDLE

Behaviour:
- Reset (async, any state): state=IDLE, all outputs 0, last_gnt=M1 (so M0 wins the first tie), lock flag and lock_cnt cleared. An in-flight transfer is dropped and never acked.
- FSM states: IDLE, XFER, WAIT, ACK.
- IDLE, arbitration:
  - If the lock flag is set, only the owner is considered. If the owner's req is low, clear the lock and arbitrate normally in the same cycle.
  - Otherwise: a single requester wins. If both request, the winner is the master that is not last_gnt.
  - On a win: latch owner, we, addr and wdata into the bus_* registers and go to XFER. With no request, stay in IDLE.
- XFER (1 cycle):
  - bus_we_o = latched we. This is the only cycle bus_we_o can be 1.
  - Write: go to ACK.
  - Read with RD_LAT=0: capture bus_rdata_i at the end of XFER, go to ACK.
  - Read with RD_LAT>0: go to WAIT.
- WAIT: down-counter runs RD_LAT cycles. bus_addr_o is held. Capture bus_rdata_i into the owner's rdata on the last WAIT cycle, then go to ACK.
- ACK (1 cycle):
  - Owner's ack_o=1 and last_gnt=owner.
  - If owner lock_i=1 and lock_cnt+1 < MAX_LOCK: set the lock flag and increment lock_cnt.
  - Otherwise: clear the lock flag and lock_cnt.
  - Always go to IDLE.
- Latency, with the request first seen in IDLE at cycle N:
  - Write: bus_we_o at N+1, ack at N+2.
  - Read: ack at N+2+RD_LAT.
  - Back-to-back writes from one master complete every 3 cycles.
- Master rule: req and request fields stay stable from assertion through the ack cycle. Request changes take effect in the following IDLE cycle. The arbiter samples request fields only in IDLE; later changes are ignored.
- mX_rdata_o changes only on a read completion for that master and holds otherwise; writes leave it unchanged.
- bus_addr_o and bus_wdata_o hold their last values outside XFER/WAIT. bus_we_o is 0 outside XFER.
- grant_o is the owner one-hot during XFER/WAIT/ACK and 00 in IDLE. Exactly one ack_o is high at a time.
- Lock starvation bound: the other master waits at most MAX_LOCK transfers.

Test Plan:
1. Single write: M0 write addr 0x2000, data 0xA5 at cycle N -> bus_we_o=1 only at N+1 with bus_addr_o=0x2000, bus_wdata_o=0xA5; m0_ack_o at N+2; grant_o=01 at N+1..N+2.
2. Read latency: RD_LAT=1, M1 reads 0x1000 with bus_rdata_i=20 -> bus_we_o stays 0; m1_ack_o at N+3 with m1_rdata_o=20; m0_rdata_o unchanged.
3. Round-robin: from reset, both masters issue continuous writes -> grant order M0,M1,M0,M1, one ack every 3 cycles, never both acks at once.
4. Lock bound: MAX_LOCK=4, M0 lock=1 with continuous writes, M1 requesting -> M0 gets 4 consecutive grants, then M1 is granted.
5. Reset mid-read: RD_LAT=3, assert rst_i in WAIT -> all outputs 0 immediately, no ack issued. After release with both masters requesting, M0 wins.
6. Write ignores RD_LAT: RD_LAT=3, M1 write 0x2004 -> ack at N+2, no WAIT cycles; busy_o high for exactly 2 cycles.

Source files
------------

// File: rtl/module_arbitro_de_bus.sv
// Two-master bus arbiter: round-robin grant with bounded locking, one registered
// request at a time to the bus conductor and a one-cycle ack back to the owner.
module module_arbitro_de_bus #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int RD_LAT   = 1,
  parameter int MAX_LOCK = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  input  logic              m0_lock_i,
  output logic              m0_ack_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  input  logic              m1_lock_i,
  output logic              m1_ack_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  output logic [1:0]        grant_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {IDLE, XFER, WAIT, ACK} state_t;

  localparam logic [2:0] WAIT_INIT = (RD_LAT > 0) ? 3'(RD_LAT - 1) : 3'd0;
  localparam logic [4:0] LOCK_LIM  = 5'(MAX_LOCK);

  state_t            state, state_nxt;
  logic              owner, last_gnt, lock_flag, we_lat;
  logic [3:0]        lock_cnt;
  logic [2:0]        wait_cnt;
  logic [ADDR_W-1:0] addr_lat;
  logic [DATA_W-1:0] wdata_lat, rdata0, rdata1;
  logic              win, win_id, lock_drop, lock_keep, capture;
  logic              owner_req, owner_lock;

  assign owner_req  = owner ? m1_req_i  : m0_req_i;
  assign owner_lock = owner ? m1_lock_i : m0_lock_i;
  assign lock_keep  = owner_lock && (({1'b0, lock_cnt} + 5'd1) < LOCK_LIM);

  // A held lock only yields once its owner stops requesting; then arbitrate in the same cycle.
  always_comb begin
    win       = 1'b0;
    win_id    = 1'b0;
    lock_drop = 1'b0;
    if (lock_flag && owner_req) begin
      win    = 1'b1;
      win_id = owner;
    end else begin
      lock_drop = lock_flag;
      if (m0_req_i && m1_req_i) begin
        win    = 1'b1;
        win_id = ~last_gnt;
      end else if (m0_req_i) begin
        win    = 1'b1;
        win_id = 1'b0;
      end else if (m1_req_i) begin
        win    = 1'b1;
        win_id = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    bus_we_o  = 1'b0;
    grant_o   = 2'b00;
    busy_o    = (state != IDLE);
    m0_ack_o  = 1'b0;
    m1_ack_o  = 1'b0;
    unique case (state)
      IDLE: if (win) state_nxt = XFER;
      XFER: begin
        bus_we_o = we_lat;
        grant_o  = owner ? 2'b10 : 2'b01;
        if (we_lat) begin
          state_nxt = ACK;
        end else if (RD_LAT == 0) begin
          capture   = 1'b1;
          state_nxt = ACK;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        grant_o = owner ? 2'b10 : 2'b01;
        if (wait_cnt == 3'd0) begin
          capture   = 1'b1;
          state_nxt = ACK;
        end
      end
      ACK: begin
        grant_o   = owner ? 2'b10 : 2'b01;
        m0_ack_o  = ~owner;
        m1_ack_o  = owner;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are latched only on a win in IDLE; later master changes are ignored.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      owner     <= 1'b0;
      last_gnt  <= 1'b1;
      lock_flag <= 1'b0;
      lock_cnt  <= 4'd0;
      wait_cnt  <= 3'd0;
      we_lat    <= 1'b0;
      addr_lat  <= '0;
      wdata_lat <= '0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      if (capture) begin
        if (owner) rdata1 <= bus_rdata_i;
        else       rdata0 <= bus_rdata_i;
      end
      case (state)
        IDLE: begin
          if (lock_drop) begin
            lock_flag <= 1'b0;
            lock_cnt  <= 4'd0;
          end
          if (win) begin
            owner     <= win_id;
            we_lat    <= win_id ? m1_we_i    : m0_we_i;
            addr_lat  <= win_id ? m1_addr_i  : m0_addr_i;
            wdata_lat <= win_id ? m1_wdata_i : m0_wdata_i;
          end
        end
        XFER: wait_cnt <= WAIT_INIT;
        WAIT: if (wait_cnt != 3'd0) wait_cnt <= wait_cnt - 3'd1;
        ACK: begin
          last_gnt <= owner;
          if (lock_keep) begin
            lock_flag <= 1'b1;
            lock_cnt  <= lock_cnt + 4'd1;
          end else begin
            lock_flag <= 1'b0;
            lock_cnt  <= 4'd0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus_addr_o  = addr_lat;
  assign bus_wdata_o = wdata_lat;
  assign m0_rdata_o  = rdata0;
  assign m1_rdata_o  = rdata1;

endmodule

// File: tb/tb_module_arbitro_de_bus.sv
// Directed bench for module_arbitro_de_bus: per-cycle vector table plus a
// hand-written asynchronous reset during a read wait.
module tb_module_arbitro_de_bus;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 32;
  localparam int RD_LAT   = 3;
  localparam int MAX_LOCK = 4;

  localparam logic [2:0] NO = 3'b000;  // {req, we, lock}
  localparam logic [2:0] WR = 3'b110;
  localparam logic [2:0] RD = 3'b100;
  localparam logic [2:0] WL = 3'b111;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              m0_req = 1'b0, m0_we = 1'b0, m0_lock = 1'b0, m0_ack;
  logic [ADDR_W-1:0] m0_addr = '0;
  logic [DATA_W-1:0] m0_wdata = '0, m0_rdata;
  logic              m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0, m1_ack;
  logic [ADDR_W-1:0] m1_addr = '0;
  logic [DATA_W-1:0] m1_wdata = '0, m1_rdata;
  logic              bus_we, busy;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata = '0;
  logic [1:0]        grant;

  always #5 clk = ~clk;

  module_arbitro_de_bus #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .MAX_LOCK(MAX_LOCK)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_lock_i(m0_lock), .m0_ack_o(m0_ack), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_lock_i(m1_lock), .m1_ack_o(m1_ack), .m1_rdata_o(m1_rdata),
    .bus_we_o(bus_we), .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata),
    .bus_rdata_i(bus_rdata), .grant_o(grant), .busy_o(busy)
  );

  typedef struct {
    logic        rst;
    logic [2:0]  c0;
    logic [31:0] a0, d0;
    logic [2:0]  c1;
    logic [31:0] a1, d1;
    logic [31:0] rd;
    logic        e_we;
    logic [31:0] e_addr, e_wdata;
    logic [1:0]  e_gnt;
    logic        e_busy;
    logic [1:0]  e_ack;
    logic [31:0] e_rd0, e_rd1;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic r, input logic [2:0] c0, input logic [31:0] a0, input logic [31:0] d0,
                     input logic [2:0] c1, input logic [31:0] a1, input logic [31:0] d1, input logic [31:0] rd,
                     input logic we, input logic [31:0] addr, input logic [31:0] wdata, input logic [1:0] gnt,
                     input logic bsy, input logic [1:0] ack, input logic [31:0] rd0, input logic [31:0] rd1);
    vec_t v;
    v.rst = r; v.c0 = c0; v.a0 = a0; v.d0 = d0; v.c1 = c1; v.a1 = a1; v.d1 = d1; v.rd = rd;
    v.e_we = we; v.e_addr = addr; v.e_wdata = wdata; v.e_gnt = gnt; v.e_busy = bsy;
    v.e_ack = ack; v.e_rd0 = rd0; v.e_rd1 = rd1;
    tbl.push_back(v);
  endtask

  // Write transfer (XFER, ACK, back to IDLE) with fixed master addresses 0x10/0x20.
  task automatic wr3(input logic [2:0] c0, input logic [2:0] c1, input logic own);
    logic [31:0] a, d;
    logic [1:0]  g;
    a = own ? 32'h20 : 32'h10;
    d = own ? 32'h200 : 32'h100;
    g = own ? 2'b10 : 2'b01;
    add(1'b0, c0, 32'h10, 32'h100, c1, 32'h20, 32'h200, 32'h0, 1'b1, a, d, g, 1'b1, 2'b00, 32'h0, 32'h0);
    add(1'b0, c0, 32'h10, 32'h100, c1, 32'h20, 32'h200, 32'h0, 1'b0, a, d, g, 1'b1, g, 32'h0, 32'h0);
    add(1'b0, c0, 32'h10, 32'h100, c1, 32'h20, 32'h200, 32'h0, 1'b0, a, d, 2'b00, 1'b0, 2'b00, 32'h0, 32'h0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    rst = v.rst;
    {m0_req, m0_we, m0_lock} = v.c0;
    m0_addr = v.a0; m0_wdata = v.d0;
    {m1_req, m1_we, m1_lock} = v.c1;
    m1_addr = v.a1; m1_wdata = v.d1;
    bus_rdata = v.rd;
  endtask

  task automatic compare(input int i, input vec_t v);
    chk($sformatf("v%0d bus_we", i), 32'(bus_we), 32'(v.e_we));
    chk($sformatf("v%0d bus_addr", i), bus_addr, v.e_addr);
    chk($sformatf("v%0d bus_wdata", i), bus_wdata, v.e_wdata);
    chk($sformatf("v%0d grant", i), 32'(grant), 32'(v.e_gnt));
    chk($sformatf("v%0d busy", i), 32'(busy), 32'(v.e_busy));
    chk($sformatf("v%0d ack", i), 32'({m1_ack, m0_ack}), 32'(v.e_ack));
    chk($sformatf("v%0d m0_rdata", i), m0_rdata, v.e_rd0);
    chk($sformatf("v%0d m1_rdata", i), m1_rdata, v.e_rd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, then M0 single write 0x2000 <- 0xA5
    add(1'b1, NO, 32'h0, 32'h0, NO, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 2'b00, 32'h0, 32'h0);
    add(1'b0, WR, 32'h2000, 32'hA5, NO, 32'h0, 32'h0, 32'h0, 1'b1, 32'h2000, 32'hA5, 2'b01, 1'b1, 2'b00, 32'h0, 32'h0);
    add(1'b0, WR, 32'h2000, 32'hA5, NO, 32'h0, 32'h0, 32'h0, 1'b0, 32'h2000, 32'hA5, 2'b01, 1'b1, 2'b01, 32'h0, 32'h0);
    add(1'b0, WR, 32'h2000, 32'hA5, NO, 32'h0, 32'h0, 32'h0, 1'b0, 32'h2000, 32'hA5, 2'b00, 1'b0, 2'b00, 32'h0, 32'h0);
    add(1'b0, NO, 32'h2000, 32'hA5, NO, 32'h0, 32'h0, 32'h0, 1'b0, 32'h2000, 32'hA5, 2'b00, 1'b0, 2'b00, 32'h0, 32'h0);
    // M1 write 0x2004: no WAIT cycles despite RD_LAT=3, busy for exactly two cycles
    add(1'b0, NO, 32'h2000, 32'hA5, WR, 32'h2004, 32'h5A, 32'h0, 1'b1, 32'h2004, 32'h5A, 2'b10, 1'b1, 2'b00, 32'h0, 32'h0);
    add(1'b0, NO, 32'h2000, 32'hA5, WR, 32'h2004, 32'h5A, 32'h0, 1'b0, 32'h2004, 32'h5A, 2'b10, 1'b1, 2'b10, 32'h0, 32'h0);
    add(1'b0, NO, 32'h2000, 32'hA5, WR, 32'h2004, 32'h5A, 32'h0, 1'b0, 32'h2004, 32'h5A, 2'b00, 1'b0, 2'b00, 32'h0, 32'h0);
    add(1'b0, NO, 32'h2000, 32'hA5, NO, 32'h2004, 32'h5A, 32'h0, 1'b0, 32'h2004, 32'h5A, 2'b00, 1'b0, 2'b00, 32'h0, 32'h0);
    // M1 read 0x1000: only the value present in the last WAIT cycle (20) is captured
    add(1'b0, NO, 32'h2000, 32'hA5, RD, 32'h1000, 32'h77, 32'hDEAD, 1'b0, 32'h1000, 32'h77, 2'b10, 1'b1, 2'b00, 32'h0, 32'h0);
    add(1'b0, NO, 32'h2000, 32'hA5, RD, 32'h1000, 32'h77, 32'hDEAD, 1'b0, 32'h1000, 32'h77, 2'b10, 1'b1, 2'b00, 32'h0, 32'h0);
    add(1'b0, NO, 32'h2000, 32'hA5, RD, 32'h1000, 32'h77, 32'hBEEF, 1'b0, 32'h1000, 32'h77, 2'b10, 1'b1, 2'b00, 32'h0, 32'h0);
    add(1'b0, NO, 32'h2000, 32'hA5, RD, 32'h1000, 32'h77, 32'hBEEF, 1'b0, 32'h1000, 32'h77, 2'b10, 1'b1, 2'b00, 32'h0, 32'h0);
    add(1'b0, NO, 32'h2000, 32'hA5, RD, 32'h1000, 32'h77, 32'd20, 1'b0, 32'h1000, 32'h77, 2'b10, 1'b1, 2'b10, 32'h0, 32'd20);
    add(1'b0, NO, 32'h2000, 32'hA5, RD, 32'h1000, 32'h77, 32'h99, 1'b0, 32'h1000, 32'h77, 2'b00, 1'b0, 2'b00, 32'h0, 32'd20);
    add(1'b0, NO, 32'h2000, 32'hA5, NO, 32'h1000, 32'h77, 32'h99, 1'b0, 32'h1000, 32'h77, 2'b00, 1'b0, 2'b00, 32'h0, 32'd20);
    // M0 read 0x3000 lands in m0_rdata only
    add(1'b0, RD, 32'h3000, 32'hA5, NO, 32'h1000, 32'h77, 32'hDEAD, 1'b0, 32'h3000, 32'hA5, 2'b01, 1'b1, 2'b00, 32'h0, 32'd20);
    add(1'b0, RD, 32'h3000, 32'hA5, NO, 32'h1000, 32'h77, 32'hDEAD, 1'b0, 32'h3000, 32'hA5, 2'b01, 1'b1, 2'b00, 32'h0, 32'd20);
    add(1'b0, RD, 32'h3000, 32'hA5, NO, 32'h1000, 32'h77, 32'hBEEF, 1'b0, 32'h3000, 32'hA5, 2'b01, 1'b1, 2'b00, 32'h0, 32'd20);
    add(1'b0, RD, 32'h3000, 32'hA5, NO, 32'h1000, 32'h77, 32'hBEEF, 1'b0, 32'h3000, 32'hA5, 2'b01, 1'b1, 2'b00, 32'h0, 32'd20);
    add(1'b0, RD, 32'h3000, 32'hA5, NO, 32'h1000, 32'h77, 32'h1234, 1'b0, 32'h3000, 32'hA5, 2'b01, 1'b1, 2'b01, 32'h1234, 32'd20);
    add(1'b0, RD, 32'h3000, 32'hA5, NO, 32'h1000, 32'h77, 32'h99, 1'b0, 32'h3000, 32'hA5, 2'b00, 1'b0, 2'b00, 32'h1234, 32'd20);
    add(1'b0, NO, 32'h3000, 32'hA5, NO, 32'h1000, 32'h77, 32'h99, 1'b0, 32'h3000, 32'hA5, 2'b00, 1'b0, 2'b00, 32'h1234, 32'd20);
    // Reset with both requesting, then round-robin M0,M1,M0,M1
    add(1'b1, WR, 32'h10, 32'h100, WR, 32'h20, 32'h200, 32'h0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 2'b00, 32'h0, 32'h0);
    for (int k = 0; k < 4; k++) wr3(WR, WR, k[0]);
    // M0 locked: four consecutive grants, then M1
    for (int k = 0; k < MAX_LOCK; k++) wr3(WL, WR, 1'b0);
    wr3(WL, WR, 1'b1);
    add(1'b0, NO, 32'h10, 32'h100, NO, 32'h20, 32'h200, 32'h0, 1'b0, 32'h20, 32'h200, 2'b00, 1'b0, 2'b00, 32'h0, 32'h0);
    // M1 takes the lock then drops req: M0 is granted in that same IDLE cycle
    add(1'b0, NO, 32'h10, 32'h100, WL, 32'h30, 32'h300, 32'h0, 1'b1, 32'h30, 32'h300, 2'b10, 1'b1, 2'b00, 32'h0, 32'h0);
    add(1'b0, NO, 32'h10, 32'h100, WL, 32'h30, 32'h300, 32'h0, 1'b0, 32'h30, 32'h300, 2'b10, 1'b1, 2'b10, 32'h0, 32'h0);
    add(1'b0, NO, 32'h10, 32'h100, WL, 32'h30, 32'h300, 32'h0, 1'b0, 32'h30, 32'h300, 2'b00, 1'b0, 2'b00, 32'h0, 32'h0);
    add(1'b0, WR, 32'h10, 32'h100, NO, 32'h30, 32'h300, 32'h0, 1'b1, 32'h10, 32'h100, 2'b01, 1'b1, 2'b00, 32'h0, 32'h0);
    add(1'b0, WR, 32'h10, 32'h100, NO, 32'h30, 32'h300, 32'h0, 1'b0, 32'h10, 32'h100, 2'b01, 1'b1, 2'b01, 32'h0, 32'h0);
    add(1'b0, WR, 32'h10, 32'h100, NO, 32'h30, 32'h300, 32'h0, 1'b0, 32'h10, 32'h100, 2'b00, 1'b0, 2'b00, 32'h0, 32'h0);
    add(1'b0, NO, 32'h10, 32'h100, NO, 32'h30, 32'h300, 32'h0, 1'b0, 32'h10, 32'h100, 2'b00, 1'b0, 2'b00, 32'h0, 32'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      apply(tbl[i]);
      @(posedge clk);
      #1;
      compare(i, tbl[i]);
    end

    // Asynchronous reset while an M0 read sits in WAIT
    @(negedge clk);
    rst = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_lock = 1'b0; m0_addr = 32'h4000; m0_wdata = 32'h600;
    m1_req = 1'b0; m1_we = 1'b0; m1_lock = 1'b0; m1_addr = 32'h50; m1_wdata = 32'h500;
    bus_rdata = 32'h0;
    @(posedge clk); #1;
    chk("rst_mid xfer grant", 32'(grant), 32'h1);
    @(posedge clk); #1;
    chk("rst_mid wait busy", 32'(busy), 32'h1);
    chk("rst_mid wait addr", bus_addr, 32'h4000);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid bus_we", 32'(bus_we), 32'h0);
    chk("rst_mid bus_addr", bus_addr, 32'h0);
    chk("rst_mid bus_wdata", bus_wdata, 32'h0);
    chk("rst_mid grant", 32'(grant), 32'h0);
    chk("rst_mid busy", 32'(busy), 32'h0);
    chk("rst_mid ack", 32'({m1_ack, m0_ack}), 32'h0);
    m1_req = 1'b1; m1_we = 1'b1;
    bus_rdata = 32'h4242;
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_hold ack", 32'({m1_ack, m0_ack}), 32'h0);
      chk("rst_hold busy", 32'(busy), 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst grant", 32'(grant), 32'h1);
    chk("post_rst addr", bus_addr, 32'h4000);
    chk("post_rst ack", 32'({m1_ack, m0_ack}), 32'h0);
    repeat (RD_LAT) begin
      @(posedge clk); #1;
      chk("post_rst wait ack", 32'({m1_ack, m0_ack}), 32'h0);
    end
    @(posedge clk); #1;
    chk("post_rst read ack", 32'({m1_ack, m0_ack}), 32'h1);
    chk("post_rst m0_rdata", m0_rdata, 32'h4242);
    chk("post_rst m1_rdata", m1_rdata, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
